// File: rtl/player_move_ctrl.sv
// player_move_ctrl: debounces the four direction buttons, divides clk into the move clock btnClk2,
// and produces registered per-direction move permissions bounded by the screen edges.
// Ports:
//   clk                 system clock, all state on its rising edge
//   rst                 asynchronous active-low reset
//   btns[3:0]           raw buttons: [3]=up [2]=down [1]=left [0]=right
//   hPos, vPos          player top-left position fed back from the player object
//   btns_db[3:0]        debounced buttons, same bit order
//   btnClk2             divided move clock, period 2*MOVE_DIV
//   up/down/left/rightEnable  registered move permissions
// Optional feature macro: PLAYER_DIAG_MOVE_EN (allows one vertical plus one horizontal enable together).
module player_move_ctrl #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned MOVE_DIV  = 2500000,
    parameter int unsigned H_MAX     = 640,
    parameter int unsigned V_MAX     = 480,
    parameter int unsigned OBJ_W     = 12,
    parameter int unsigned OBJ_H     = 12,
    parameter int unsigned STEP      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btns,
    input  logic [31:0] hPos,
    input  logic [31:0] vPos,
    output logic [3:0]  btns_db,
    output logic        btnClk2,
    output logic        upEnable,
    output logic        downEnable,
    output logic        leftEnable,
    output logic        rightEnable
);
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam int unsigned DW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(MOVE_DIV - 1);

    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, en_q, en_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]      div_q, div_d;
    logic               clk2_q, clk2_d;
    logic               up_c, dn_c, lf_c, rt_c;

    always_comb begin
        sync1_d = btns;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            // Counter only runs while the synced bit disagrees with the output; any match restarts it.
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST)
                    db_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        clk2_d = (div_q == DIV_LAST) ? ~clk2_q : clk2_q;
        // 33-bit sums so positions near 2^32-1 deny motion instead of wrapping.
        up_c = db_q[3] & ~db_q[2] & (vPos >= 32'(STEP));
        dn_c = db_q[2] & ~db_q[3] & (({1'b0, vPos} + 33'(OBJ_H) + 33'(STEP)) <= 33'(V_MAX));
        lf_c = db_q[1] & ~db_q[0] & (hPos >= 32'(STEP));
        rt_c = db_q[0] & ~db_q[1] & (({1'b0, hPos} + 33'(OBJ_W) + 33'(STEP)) <= 33'(H_MAX));
`ifdef PLAYER_DIAG_MOVE_EN
        en_d = {up_c, dn_c, lf_c, rt_c};
`else
        en_d = {up_c, dn_c & ~up_c, lf_c & ~up_c & ~dn_c, rt_c & ~up_c & ~dn_c & ~lf_c};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            clk2_q  <= 1'b0;
            en_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clk2_q  <= clk2_d;
            en_q    <= en_d;
        end
    end

    assign btns_db     = db_q;
    assign btnClk2     = clk2_q;
    assign upEnable    = en_q[3];
    assign downEnable  = en_q[2];
    assign leftEnable  = en_q[1];
    assign rightEnable = en_q[0];
endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: directed vector table plus hand sequences for reset, latency, glitch and boundary cases.
module tb_player_move_ctrl;
    localparam int DB = 4;
`ifdef PLAYER_DIAG_MOVE_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btns = '0;
    logic [31:0] hPos = 32'd100, vPos = 32'd100;
    logic [3:0]  btns_db;
    logic        btnClk2, upEnable, downEnable, leftEnable, rightEnable;
    logic [3:0]  ens;
    int          tests = 0, fails = 0;

    assign ens = {upEnable, downEnable, leftEnable, rightEnable};

    player_move_ctrl #(.DB_CYCLES(DB), .MOVE_DIV(3)) dut (
        .clk(clk), .rst(rst), .btns(btns), .hPos(hPos), .vPos(vPos),
        .btns_db(btns_db), .btnClk2(btnClk2), .upEnable(upEnable),
        .downEnable(downEnable), .leftEnable(leftEnable), .rightEnable(rightEnable)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  b;
        logic [31:0] h;
        logic [31:0] v;
        logic [3:0]  db;
        logic [3:0]  en_nd;
        logic [3:0]  en_dg;
    } vec_t;

    vec_t vt [17];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // {btns, hPos, vPos, btns_db, enables single-move, enables diagonal}; enables are {up,down,left,right}
        vt[0]  = {4'b1000, 32'd100, 32'd100, 4'b1000, 4'b1000, 4'b1000};
        vt[1]  = {4'b0001, 32'd627, 32'd100, 4'b0001, 4'b0001, 4'b0001};
        vt[2]  = {4'b0001, 32'd628, 32'd100, 4'b0001, 4'b0000, 4'b0000};
        vt[3]  = {4'b1000, 32'd100, 32'd0,   4'b1000, 4'b0000, 4'b0000};
        vt[4]  = {4'b1010, 32'd100, 32'd100, 4'b1010, 4'b1000, 4'b1010};
        vt[5]  = {4'b1100, 32'd100, 32'd100, 4'b1100, 4'b0000, 4'b0000};
        vt[6]  = {4'b0011, 32'd100, 32'd100, 4'b0011, 4'b0000, 4'b0000};
        vt[7]  = {4'b0100, 32'd100, 32'd467, 4'b0100, 4'b0100, 4'b0100};
        vt[8]  = {4'b0100, 32'd100, 32'd468, 4'b0100, 4'b0000, 4'b0000};
        vt[9]  = {4'b0010, 32'd1,   32'd100, 4'b0010, 4'b0010, 4'b0010};
        vt[10] = {4'b0010, 32'd0,   32'd100, 4'b0010, 4'b0000, 4'b0000};
        vt[11] = {4'b0101, 32'd100, 32'd100, 4'b0101, 4'b0100, 4'b0101};
        vt[12] = {4'b0001, 32'hFFFF_FFF8, 32'd100, 4'b0001, 4'b0000, 4'b0000};
        vt[13] = {4'b0100, 32'd100, 32'hFFFF_FFFF, 4'b0100, 4'b0000, 4'b0000};
        vt[14] = {4'b1111, 32'd100, 32'd100, 4'b1111, 4'b0000, 4'b0000};
        vt[15] = {4'b1001, 32'd100, 32'd0,   4'b1001, 4'b0001, 4'b0001};
        vt[16] = {4'b0110, 32'd100, 32'd100, 4'b0110, 4'b0100, 4'b0110};

        // reset held low, then released; move clock phase after release
        #2 rst = 1'b0;
        tick(2);
        chk("rst_db", {28'd0, btns_db}, 32'd0);
        chk("rst_clk2", {31'd0, btnClk2}, 32'd0);
        chk("rst_en", {28'd0, ens}, 32'd0);
        rst = 1'b1;
        tick(2);
        chk("clk2_c2", {31'd0, btnClk2}, 32'd0);
        tick(1);
        chk("clk2_c3", {31'd0, btnClk2}, 32'd1);
        tick(2);
        chk("clk2_c5", {31'd0, btnClk2}, 32'd1);
        tick(1);
        chk("clk2_c6", {31'd0, btnClk2}, 32'd0);
        tick(3);
        chk("clk2_c9", {31'd0, btnClk2}, 32'd1);

        // clean up press: btns_db exactly DB+2 cycles later, enable one cycle after
        btns = 4'b1000; vPos = 32'd100; hPos = 32'd100;
        tick(5);
        chk("lat_db_c5", {28'd0, btns_db}, 32'd0);
        tick(1);
        chk("lat_db_c6", {28'd0, btns_db}, 32'h8);
        chk("lat_up_c6", {31'd0, upEnable}, 32'd0);
        tick(1);
        chk("lat_up_c7", {31'd0, upEnable}, 32'd1);

        // 3-cycle glitch on right must be rejected
        btns = 4'b1001;
        tick(3);
        btns = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            chk("glitch_db", {28'd0, btns_db}, 32'h8);
            tick(1);
        end

        for (int i = 0; i < 17; i++) begin
            btns = vt[i].b; hPos = vt[i].h; vPos = vt[i].v;
            tick(DB + 4);
            chk($sformatf("vec%0d_db", i), {28'd0, btns_db}, {28'd0, vt[i].db});
            chk($sformatf("vec%0d_en", i), {28'd0, ens}, {28'd0, DIAG ? vt[i].en_dg : vt[i].en_nd});
        end

        // right edge boundary: enable tracks hPos one cycle later
        btns = 4'b0001; hPos = 32'd627; vPos = 32'd100;
        tick(DB + 4);
        chk("bnd_627", {31'd0, rightEnable}, 32'd1);
        hPos = 32'd628;
        tick(1);
        chk("bnd_628", {31'd0, rightEnable}, 32'd0);
        hPos = 32'd627;
        tick(1);
        chk("bnd_627_again", {31'd0, rightEnable}, 32'd1);

        // reset mid-debounce with counter at 3
        btns = 4'b0000;
        tick(DB + 4);
        chk("pre_rst_db", {28'd0, btns_db}, 32'd0);
        btns = 4'b0001;
        tick(5);
        chk("mid_db_before_rst", {28'd0, btns_db}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_db", {28'd0, btns_db}, 32'd0);
        chk("mid_rst_en", {28'd0, ens}, 32'd0);
        tick(1);
        rst = 1'b1;
        tick(5);
        chk("post_rst_db_c5", {28'd0, btns_db}, 32'd0);
        tick(1);
        chk("post_rst_db_c6", {28'd0, btns_db}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000: consecutive stable clk cycles needed to accept a button change.
REQ-002 SHALL have parameter MOVE_DIV, default 2500000: clk cycles per btnClk2 half-period.
REQ-003 SHALL have parameters H_MAX 640, V_MAX 480, OBJ_W 12, OBJ_H 12, STEP 1: screen limits, player size and pixels per move (all unsigned).
REQ-004 SHALL have clk  in  1  single system clock; all state on its rising edge.
REQ-005 SHALL have rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have btns  in  4  raw asynchronous buttons; [3]=up, [2]=down, [1]=left, [0]=right.
REQ-007 SHALL have hPos, vPos  in  32 each  current player top-left position fed back from the player object.
REQ-008 SHALL have btns_db  out  4  debounced buttons, same bit order, registered.
REQ-009 SHALL have btnClk2  out  1  divided move clock, 50% duty, registered.
REQ-010 SHALL have upEnable, downEnable, leftEnable, rightEnable  out  1 each  registered per-direction move permission.

Function
REQ-011 SHALL pass each btns bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep one counter per button (width ceil(log2(DB_CYCLES+1))); it clears whenever the synced bit equals btns_db, otherwise increments.
REQ-013 SHALL update btns_db bit and clear its counter on the cycle the counter reaches DB_CYCLES-1 with the mismatch still present; any bounce back clears the counter with no output change.
REQ-014 SHALL give a total latency of exactly DB_CYCLES+2 clk cycles from a clean raw edge to the btns_db edge.
REQ-015 SHALL run a free-running divider 0..MOVE_DIV-1; at terminal count it wraps to 0 and toggles btnClk2 (period 2*MOVE_DIV cycles).
REQ-016 SHALL assert upEnable only if btns_db[3]=1, btns_db[2]=0, and vPos >= STEP.
REQ-017 SHALL assert downEnable only if btns_db[2]=1, btns_db[3]=0, and vPos+OBJ_H+STEP <= V_MAX.
REQ-018 SHALL assert leftEnable only if btns_db[1]=1, btns_db[0]=0, and hPos >= STEP.
REQ-019 SHALL assert rightEnable only if btns_db[0]=1, btns_db[1]=0, and hPos+OBJ_W+STEP <= H_MAX.
REQ-020 SHALL evaluate boundary sums in 33-bit arithmetic so that positions near 2^32-1 deny motion rather than wrap.
REQ-021 SHALL register enables one clk after the btns_db/hPos/vPos change that causes them; opposing buttons pressed together force both of that axis low.
REQ-022 SHALL keep enables independent of btnClk2 phase; the downstream block samples them on its own btnClk2 edge.

Reset
REQ-023 SHALL, while rst=0, drive btns_db=4'b0000, btnClk2=0, all enables=0, and clear synchronizers, debounce counters and divider.
REQ-024 SHALL take effect mid-debounce or mid-period immediately; after release the first btnClk2 rising edge occurs MOVE_DIV cycles later.

Configuration
REQ-025 SHALL honour macro PLAYER_DIAG_MOVE_EN: when defined, a vertical and a horizontal enable may be high together (diagonal move).
REQ-026 SHALL, without PLAYER_DIAG_MOVE_EN, allow at most one enable high, priority up > down > left > right among the candidates permitted by REQ-016..019.

Verification (DB_CYCLES=4, MOVE_DIV=3, defaults otherwise)
REQ-027 SHALL cover: rst low then released -> all outputs 0; btnClk2 rises at cycle 3 after release, falls at 6, period 6.
REQ-028 SHALL cover: btns[3] 0->1 clean, vPos=100 -> btns_db[3]=1 exactly 6 cycles later, upEnable=1 one cycle after that.
REQ-029 SHALL cover: btns[0] pulses high 3 cycles then low -> btns_db[0] stays 0.
REQ-030 SHALL cover: right held, hPos=627 -> rightEnable=1; hPos=628 -> rightEnable=0 next cycle; vPos=0 with up held -> upEnable=0.
REQ-031 SHALL cover: up+left held, vPos=hPos=100 -> with PLAYER_DIAG_MOVE_EN both enables 1; without it only upEnable=1; up+down held -> both 0.
REQ-032 SHALL cover: rst pulsed low mid-debounce, counter at 3 -> btns_db stays 0; a full DB_CYCLES+2 interval is required after release.
